smlsib_auth_ctrl: RTL and testbench

//  Authentication controller for a secure SIB. Holds a KEY_W-bit key register in series ahead of the SIB scan cell.

---
 rtl/smlsib_pkg.sv | 13 +
 rtl/auth_key_sr.sv | 38 +++
 rtl/smlsib_auth_ctrl.sv | 101 ++++++++++
 tb/tb_smlsib_auth_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/smlsib_pkg.sv
// rtl/smlsib_pkg.sv - shared types and constants for the secure SIB authentication controller
package smlsib_pkg;

  localparam int FAILCNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ARMED,
    LOCKED
  } auth_state_t;

endpackage

// File: rtl/auth_key_sr.sv
// rtl/auth_key_sr.sv - key shift register in series ahead of the SIB scan cell, LSB shifts out first
module auth_key_sr #(
  parameter int KEY_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             si_i,
  output logic [KEY_W-1:0] key_o,
  output logic             so_o
);

  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] key_d;

  // Clear has priority so a capture wipes any partial key.
  always_comb begin
    key_d = key_q;
    if (clr_i) begin
      key_d = '0;
    end else if (shift_i) begin
      key_d = {si_i, key_q[KEY_W-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q <= '0;
    end else begin
      key_q <= key_d;
    end
  end

  assign key_o = key_q;
  assign so_o  = key_q[0];

endmodule

// File: rtl/smlsib_auth_ctrl.sv
// rtl/smlsib_auth_ctrl.sv - key compare, update FSM and fail counter for one secure SIB
// Optional lockout after MAX_FAIL failed updates is enabled by defining AUTH_FAIL_LOCK_EN.
module smlsib_auth_ctrl
  import smlsib_pkg::*;
#(
  parameter int               KEY_W     = 16,
  parameter logic [KEY_W-1:0] KEY_VALUE = 16'hC3A5,
  parameter int               MAX_FAIL  = 3
) (
  input  logic                 Clock,
  input  logic                 RstBar,
  input  logic                 SI,
  input  logic                 ShiftEN,
  input  logic                 CaptureEN,
  input  logic                 UpdateEN,
  input  logic                 Select,
  output logic                 KeySO,
  output logic                 CompOut,
  output logic                 Locked,
  output logic [FAILCNT_W-1:0] FailCnt
);

`ifdef AUTH_FAIL_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  auth_state_t          state_q, state_d;
  logic [FAILCNT_W-1:0] fail_q, fail_d;
  logic                 match_q, match_d;
  logic                 fail_inc;
  logic [KEY_W-1:0]     key;

  // Strobes are mutually exclusive after qualification: cap > sh > upd.
  logic cap, sh, upd;
  assign cap = Select & CaptureEN;
  assign sh  = Select & ShiftEN & ~CaptureEN;
  assign upd = Select & UpdateEN & ~CaptureEN & ~ShiftEN;

  auth_key_sr #(
    .KEY_W (KEY_W)
  ) u_key_sr (
    .clk_i   (Clock),
    .rst_ni  (RstBar),
    .clr_i   (cap),
    .shift_i (sh),
    .si_i    (SI),
    .key_o   (key),
    .so_o    (KeySO)
  );

  assign match_d = (key == KEY_VALUE) && !Locked;

  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    fail_inc = 1'b0;
    if (state_q == LOCKED) begin
      state_d = LOCKED;
    end else if (cap) begin
      state_d = IDLE;
    end else if (sh) begin
      state_d = SHIFT;
    end else if (upd) begin
      // An update straight out of a shift never saw a settled compare, so it always fails.
      state_d  = IDLE;
      fail_inc = (state_q == SHIFT) || !match_q;
    end else if (state_q == SHIFT) begin
      state_d = ARMED;
    end
    if (fail_inc && (fail_q != '1)) begin
      fail_d = fail_q + 1'b1;
    end
    if (LOCK_EN && fail_inc && (fail_d == FAILCNT_W'(MAX_FAIL))) begin
      state_d = LOCKED;
    end
  end

  always_ff @(posedge Clock or negedge RstBar) begin
    if (!RstBar) begin
      state_q <= IDLE;
      fail_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      match_q <= match_d;
    end
  end

`ifdef AUTH_FAIL_LOCK_EN
  assign Locked = (state_q == LOCKED);
`else
  assign Locked = 1'b0;
`endif

  assign CompOut = match_q;
  assign FailCnt = fail_q;

endmodule

// File: tb/tb_smlsib_auth_ctrl.sv
// tb/tb_smlsib_auth_ctrl.sv - self-checking bench for smlsib_auth_ctrl (KEY_W=8, KEY_VALUE=8'hA5, MAX_FAIL=2)
module tb_smlsib_auth_ctrl;

  localparam int         KW = 8;
  localparam logic [7:0] KV = 8'hA5;
  localparam int         MF = 2;
`ifdef AUTH_FAIL_LOCK_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       RstBar = 1'b0;
  logic       SI = 1'b0;
  logic       ShiftEN = 1'b0;
  logic       CaptureEN = 1'b0;
  logic       UpdateEN = 1'b0;
  logic       Select = 1'b0;
  logic       KeySO;
  logic       CompOut;
  logic       Locked;
  logic [7:0] FailCnt;

  always #5 Clock = ~Clock;

  smlsib_auth_ctrl #(
    .KEY_W     (KW),
    .KEY_VALUE (KV),
    .MAX_FAIL  (MF)
  ) dut (
    .Clock     (Clock),
    .RstBar    (RstBar),
    .SI        (SI),
    .ShiftEN   (ShiftEN),
    .CaptureEN (CaptureEN),
    .UpdateEN  (UpdateEN),
    .Select    (Select),
    .KeySO     (KeySO),
    .CompOut   (CompOut),
    .Locked    (Locked),
    .FailCnt   (FailCnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference: the key as a number, a flag for "the previous cycle was a shift", and counters.
  int m_key, m_fail;
  bit m_comp, m_lastsh, m_locked;

  typedef enum int {OP_SH, OP_IDLE, OP_UPD, OP_CAP} op_t;
  typedef struct {
    op_t        op;
    logic [7:0] data;
    logic       comp;
    int         fail;
    logic       lock;
  } vec_t;
  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_key = 0; m_fail = 0; m_comp = 0; m_lastsh = 0; m_locked = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_keyso"},  32'(KeySO),   m_key & 1);
    chk({tag, "_comp"},   32'(CompOut), 32'(m_comp));
    chk({tag, "_failcnt"}, 32'(FailCnt), m_fail);
    chk({tag, "_locked"}, 32'(Locked),  32'(m_locked));
  endtask

  task automatic step(input bit sel, input bit se, input bit ce, input bit ue, input bit si);
    bit cap, sh, up, fev;
    Select = sel; ShiftEN = se; CaptureEN = ce; UpdateEN = ue; SI = si;
    cap = sel & ce;
    sh  = sel & se & !cap;
    up  = sel & ue & !cap & !sh;
    fev = up && !m_locked && (m_lastsh || !m_comp);
    m_comp = (m_key == int'(KV)) && !m_locked;
    if (cap) m_key = 0;
    else if (sh) m_key = (m_key >> 1) | (int'(si) << (KW - 1));
    if (fev && m_fail < 255) m_fail++;
    if (LK && fev && m_fail == MF) m_locked = 1;
    m_lastsh = sh;
    @(posedge Clock);
    #1;
    check_model("model");
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, b[i]);
  endtask

  task automatic do_reset();
    RstBar = 1'b0;
    Select = 0; ShiftEN = 0; CaptureEN = 0; UpdateEN = 0; SI = 0;
    #1;
    model_reset();
    chk("reset_comp", 32'(CompOut), 0);
    chk("reset_failcnt", 32'(FailCnt), 0);
    chk("reset_locked", 32'(Locked), 0);
    @(posedge Clock);
    #1;
    RstBar = 1'b1;
    check_model("reset");
  endtask

  initial begin
    vt[0]  = '{OP_SH,   8'hA5, 1'b0, 0, 1'b0};
    vt[1]  = '{OP_IDLE, 8'h00, 1'b1, 0, 1'b0};
    vt[2]  = '{OP_UPD,  8'h00, 1'b1, 0, 1'b0};
    vt[3]  = '{OP_SH,   8'h5A, 1'b0, 0, 1'b0};
    vt[4]  = '{OP_IDLE, 8'h00, 1'b0, 0, 1'b0};
    vt[5]  = '{OP_UPD,  8'h00, 1'b0, 1, 1'b0};
    vt[6]  = '{OP_SH,   8'hA5, 1'b0, 1, 1'b0};
    vt[7]  = '{OP_IDLE, 8'h00, 1'b1, 1, 1'b0};
    vt[8]  = '{OP_UPD,  8'h00, 1'b1, 1, 1'b0};
    vt[9]  = '{OP_SH,   8'h5A, 1'b0, 1, 1'b0};
    vt[10] = '{OP_IDLE, 8'h00, 1'b0, 1, 1'b0};
    vt[11] = '{OP_UPD,  8'h00, 1'b0, 2, LK};
    vt[12] = '{OP_SH,   8'hA5, 1'b0, 2, LK};
    vt[13] = '{OP_IDLE, 8'h00, !LK,  2, LK};
    vt[14] = '{OP_UPD,  8'h00, !LK,  2, LK};

    do_reset();

    for (int i = 0; i < 15; i++) begin
      case (vt[i].op)
        OP_SH:   shift_byte(vt[i].data);
        OP_IDLE: step(1, 0, 0, 0, 0);
        OP_UPD:  step(1, 0, 0, 1, 0);
        default: step(1, 0, 1, 0, 0);
      endcase
      chk($sformatf("vec%0d_comp", i),    32'(CompOut), 32'(vt[i].comp));
      chk($sformatf("vec%0d_failcnt", i), 32'(FailCnt), vt[i].fail);
      chk($sformatf("vec%0d_locked", i),  32'(Locked),  32'(vt[i].lock));
    end

    // Capture after a good key discards it; the chain then shifts out zeros.
    do_reset();
    shift_byte(KV);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("cap_comp", 32'(CompOut), 0);
    chk("cap_failcnt", 32'(FailCnt), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("cap_keyso%0d", i), 32'(KeySO), 0);
      step(1, 1, 0, 0, 1);
    end

    // Reset in the middle of a shift clears everything, partial key included.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, KV[i]);
    @(negedge Clock);
    RstBar = 1'b0;
    #1;
    chk("midrst_comp", 32'(CompOut), 0);
    chk("midrst_failcnt", 32'(FailCnt), 0);
    chk("midrst_keyso", 32'(KeySO), 0);
    model_reset();
    @(posedge Clock);
    #1;
    RstBar = 1'b1;
    shift_byte(KV);
    step(1, 0, 0, 0, 0);
    chk("postrst_match", 32'(CompOut), 1);
    step(1, 0, 0, 1, 0);
    chk("postrst_failcnt", 32'(FailCnt), 0);

    // Shift and update together: shift wins; update straight out of a shift fails.
    do_reset();
    shift_byte(KV);
    step(1, 1, 0, 1, 1);
    chk("sh_upd_nocount", 32'(FailCnt), 0);
    step(1, 0, 0, 1, 0);
    chk("upd_in_shift", 32'(FailCnt), 1);
    step(0, 1, 1, 1, 1);
    chk("desel_ignored", 32'(FailCnt), 1);

    // Saturation at 255 (lockout stops the count at MAX_FAIL instead).
    do_reset();
    repeat (260) step(1, 0, 0, 1, 0);
    chk("sat_failcnt", 32'(FailCnt), LK ? MF : 255);

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) shift_byte(KV);
      else if (r < 4) do_reset();
      else step($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
